// File: rtl/eth_tx_frame_limiter.sv
// eth_tx_frame_limiter: zero-latency AXIS pass-through that truncates frames over MAX_FRAME_LENGTH and reports each frame's length/bad/truncated status
module eth_tx_frame_limiter #(
  parameter int MAX_FRAME_LENGTH = 1518,
  parameter int LENGTH_WIDTH = $clog2(MAX_FRAME_LENGTH + 1)
) (
  input  logic                    tx_clk,
  input  logic                    tx_rst,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic [LENGTH_WIDTH-1:0] len_tdata,
  output logic                    len_bad,
  output logic                    len_truncated,
  output logic                    len_tvalid,
  input  logic                    len_tready,
  output logic                    stat_truncated,
  output logic                    stat_len_overflow
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;
  state_t state, state_nx;
  logic [LENGTH_WIDTH-1:0] count;
  logic drop, lim, acc, done, cut;
  always_comb begin
    drop = state == DROP;
    lim = !drop && count == LENGTH_WIDTH'(MAX_FRAME_LENGTH - 1);
    s_axis_tready = drop || m_axis_tready;
    m_axis_tvalid = !drop && s_axis_tvalid;
    m_axis_tdata = s_axis_tdata;
    m_axis_tlast = s_axis_tlast || lim;
    m_axis_tuser = s_axis_tuser || (lim && !s_axis_tlast);
    acc = s_axis_tvalid && s_axis_tready;
    done = acc && !drop && (s_axis_tlast || lim);
    cut = done && !s_axis_tlast;
    state_nx = !acc ? state : s_axis_tlast ? IDLE : (drop || lim) ? DROP : ACTIVE;
  end
  always_ff @(posedge tx_clk or posedge tx_rst)
    if (tx_rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge tx_clk or posedge tx_rst)
    if (tx_rst) begin
      count <= '0;
      len_tdata <= '0;
      len_bad <= 1'b0;
      len_truncated <= 1'b0;
      len_tvalid <= 1'b0;
      stat_truncated <= 1'b0;
      stat_len_overflow <= 1'b0;
    end else begin
      if (acc && !drop) count <= (s_axis_tlast || lim) ? '0 : count + 1'b1;
      stat_truncated <= cut;
      stat_len_overflow <= done && len_tvalid && !len_tready;
      if (done && (!len_tvalid || len_tready)) begin
        len_tdata <= count + 1'b1;
        len_bad <= s_axis_tuser || cut;
        len_truncated <= cut;
        len_tvalid <= 1'b1;
      end else if (len_tready) len_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_eth_tx_frame_limiter.sv
// tb_eth_tx_frame_limiter: table-driven, hand-written and randomized checks of eth_tx_frame_limiter against a frame-level model
module tb_eth_tx_frame_limiter;
  localparam int MAX = 1518;
  localparam int W = $clog2(MAX + 1);
  logic tx_clk = 0, tx_rst;
  logic [7:0] s_axis_tdata, m_axis_tdata;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [W-1:0] len_tdata;
  logic len_bad, len_truncated, len_tvalid, len_tready;
  logic stat_truncated, stat_len_overflow;
  eth_tx_frame_limiter #(.MAX_FRAME_LENGTH(MAX)) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .len_tdata(len_tdata), .len_bad(len_bad), .len_truncated(len_truncated),
    .len_tvalid(len_tvalid), .len_tready(len_tready),
    .stat_truncated(stat_truncated), .stat_len_overflow(stat_len_overflow)
  );
  always #5 tx_clk = ~tx_clk;
  typedef struct {int len; bit user; int bp; int e_len; bit e_bad; bit e_trunc;} vec_t;
  vec_t tbl[8];
  logic [9:0] out_q[$], exp_q[$];
  logic [W+1:0] len_q[$], exp_len_q[$];
  int n_trunc = 0, n_ovf = 0, exp_trunc = 0, exp_ovf = 0;
  int errors = 0, checks = 0;
  always @(negedge tx_clk)
    if (!tx_rst) begin
      if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
      if (len_tvalid && len_tready) len_q.push_back({len_truncated, len_bad, len_tdata});
      if (stat_truncated) n_trunc++;
      if (stat_len_overflow) n_ovf++;
    end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic send_frame(input int l, input bit u, input int bp, input int e_len, input bit e_bad, input bit e_trunc);
    logic [7:0] d[$];
    int n, t;
    bit acc;
    n = l > MAX ? MAX : l;
    for (int i = 0; i < l; i++) d.push_back(8'($urandom));
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, (i == n - 1) && (u || l > MAX), d[i]});
    if (e_len < 0) exp_ovf++;
    else exp_len_q.push_back({e_trunc, e_bad, W'(e_len)});
    exp_trunc += int'(e_trunc);
    for (int i = 0; i < l; i++) begin
      if (i > 0 && bp > 0 && $urandom_range(3) == 0) begin
        s_axis_tvalid = 0;
        m_axis_tready = 1'($urandom_range(1));
        @(posedge tx_clk); #1;
      end
      s_axis_tvalid = 1;
      s_axis_tdata = d[i];
      s_axis_tlast = i == l - 1;
      s_axis_tuser = u && i == l - 1;
      t = 0;
      acc = 0;
      while (!acc) begin
        m_axis_tready = i >= MAX ? 1'b0 : $urandom_range(99) >= bp;
        @(negedge tx_clk);
        if (i == MAX && t == 0) begin
          chk("drop_s_tready", s_axis_tready, 1);
          chk("drop_m_tvalid", m_axis_tvalid, 0);
        end
        acc = s_axis_tvalid && s_axis_tready;
        @(posedge tx_clk); #1;
        if (++t > 1000) begin
          errors++;
          $display("FAIL beat_timeout: byte %0d of %0d never accepted", i, l);
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $fatal(1, "timeout");
        end
      end
      if (i == n - 1) chk("len_valid_next_cycle", len_tvalid, 1);
    end
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    s_axis_tuser = 0;
  endtask
  task automatic verify(input string tag);
    logic [9:0] a, e;
    logic [W+1:0] la, le;
    repeat (3) @(posedge tx_clk);
    #1;
    chk({tag, "_beat_count"}, out_q.size(), exp_q.size());
    while (out_q.size() > 0 && exp_q.size() > 0) begin
      a = out_q.pop_front();
      e = exp_q.pop_front();
      if (a != e) chk({tag, "_beat"}, int'(a), int'(e));
    end
    checks++;
    chk({tag, "_len_count"}, len_q.size(), exp_len_q.size());
    while (len_q.size() > 0 && exp_len_q.size() > 0) begin
      la = len_q.pop_front();
      le = exp_len_q.pop_front();
      chk({tag, "_len"}, int'(la[W-1:0]), int'(le[W-1:0]));
      chk({tag, "_bad"}, int'(la[W]), int'(le[W]));
      chk({tag, "_trunc"}, int'(la[W+1]), int'(le[W+1]));
    end
    out_q.delete();
    exp_q.delete();
    len_q.delete();
    exp_len_q.delete();
    chk({tag, "_stat_trunc"}, n_trunc, exp_trunc);
    chk({tag, "_stat_ovf"}, n_ovf, exp_ovf);
  endtask
  initial begin
    int l, n;
    bit u;
    tbl = '{'{64, 0, 0, 64, 0, 0}, '{1600, 0, 0, 1518, 1, 1}, '{100, 1, 50, 100, 1, 0},
            '{1519, 0, 30, 1518, 1, 1}, '{1518, 1, 20, 1518, 1, 0}, '{1517, 0, 0, 1517, 0, 0},
            '{2, 1, 50, 2, 1, 0}, '{1, 1, 0, 1, 1, 0}};
    tx_rst = 1;
    s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0; s_axis_tuser = 0;
    m_axis_tready = 0; len_tready = 1;
    repeat (3) @(posedge tx_clk);
    #1 tx_rst = 0;
    chk("rst_len_tvalid", len_tvalid, 0);
    chk("rst_len_tdata", len_tdata, 0);
    chk("rst_len_bad", len_bad, 0);
    chk("rst_len_trunc", len_truncated, 0);
    chk("rst_stat_trunc", stat_truncated, 0);
    chk("rst_stat_ovf", stat_len_overflow, 0);
    chk("rst_m_tvalid_idle0", m_axis_tvalid, 0);
    s_axis_tvalid = 1;
    #1;
    chk("idle_m_tvalid_follows", m_axis_tvalid, 1);
    chk("idle_s_tready_follows", s_axis_tready, 0);
    s_axis_tvalid = 0;
    @(posedge tx_clk); #1;
    for (int k = 0; k < 8; k++) begin
      send_frame(tbl[k].len, tbl[k].user, tbl[k].bp, tbl[k].e_len, tbl[k].e_bad, tbl[k].e_trunc);
      verify($sformatf("tbl%0d", k));
    end
    send_frame(1, 0, 0, 1, 0, 0);
    send_frame(1518, 0, 0, 1518, 0, 0);
    verify("b2b");
    len_tready = 0;
    send_frame(60, 0, 0, 60, 0, 0);
    send_frame(60, 0, 0, -1, 0, 0);
    repeat (2) @(posedge tx_clk);
    #1;
    chk("ovf_held_valid", len_tvalid, 1);
    chk("ovf_held_len", len_tdata, 60);
    len_tready = 1;
    verify("ovf");
    chk("ovf_drained", len_tvalid, 0);
    len_tready = 0;
    send_frame(10, 0, 0, 10, 0, 0);
    len_tready = 1;
    send_frame(1, 1, 0, 1, 1, 0);
    verify("swap");
    for (int i = 0; i < 30; i++) begin
      s_axis_tvalid = 1; s_axis_tdata = 8'(i); s_axis_tlast = 0; m_axis_tready = 1;
      @(posedge tx_clk); #1;
    end
    tx_rst = 1;
    s_axis_tvalid = 0;
    @(posedge tx_clk); #1;
    tx_rst = 0;
    repeat (2) @(posedge tx_clk);
    #1;
    chk("abort_beats", out_q.size(), 30);
    chk("abort_no_entry", len_q.size(), 0);
    chk("abort_len_tvalid", len_tvalid, 0);
    out_q.delete();
    send_frame(64, 0, 0, 64, 0, 0);
    verify("after_abort");
    for (int k = 0; k < 15; k++) begin
      l = $urandom_range(4) == 0 ? $urandom_range(1516, 1600) : $urandom_range(1, 150);
      u = 1'($urandom_range(1));
      n = l > MAX ? MAX : l;
      send_frame(l, u, $urandom_range(60), n, u || l > MAX, l > MAX);
      verify($sformatf("rnd%0d", k));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
